// File: rtl/err_log_pkg.sv
// Shared definitions for the error logging path: word widths and the
// request/acknowledge handshake state encoding used by both ends of the link.
package err_log_pkg;

  localparam int ERR_W = 32;
  localparam int OVF_W = 16;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_DROP = 1'b1
  } state_e;

endpackage

// File: rtl/err_fifo.sv
// Synchronous FIFO with registered occupancy flags and a registered read port
// that holds its last popped word until the next successful pop.
module err_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             push, pop;

  // Requests are qualified by the flags as they stood before the edge.
  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CNT_FULL);
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;

endmodule

// File: rtl/err_log.sv
// Error logger: acknowledges each four-phase request once, timestamps the word
// and queues it; when the queue is full the word is counted as dropped instead.
module err_log
  import err_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   err_req,
  input  logic [ERR_W-1:0]       err_data,
  output logic                   err_ack,
  input  logic                   rd_en,
  output logic [TS_W+ERR_W-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [OVF_W-1:0]       ovf_cnt,
  input  logic                   clr_ovf
);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_e           state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             accept;
  logic             wr_en;
  logic             drop;
  logic             fifo_full;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == OVF_MAX) ? v : v + OVF_ONE;
  endfunction

  // One capture per request: only the idle state may accept.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_req) begin
          accept  = 1'b1;
          state_d = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (!err_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en = accept && !fifo_full;
  assign drop  = accept && fifo_full;

  // A clear that coincides with a drop still records that drop.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf)   ovf_d = drop ? OVF_ONE : '0;
    else if (drop) ovf_d = sat_inc(ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_ONE;
      ovf_q   <= ovf_d;
    end
  end

  assign err_ack = (state_q == S_WAIT_DROP);
  assign ovf_cnt = ovf_q;
  assign full    = fifo_full;

  err_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W + ERR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  ({ts_q, err_data}),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (fifo_full),
    .count    (count)
  );

endmodule

// File: tb/tb_err_log.sv
// Bench for err_log: cycle table for the basic handshake plus sequences for
// overflow, saturation and reset; a queue holds the words expected from pops.
module tb_err_log;
  import err_log_pkg::*;

  localparam int DEPTH = 16;
  localparam int TS_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RD_W  = TS_W + ERR_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             err_req;
  logic [ERR_W-1:0] err_data;
  logic             err_ack;
  logic             rd_en;
  logic [RD_W-1:0]  rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [OVF_W-1:0] ovf_cnt;
  logic             clr_ovf;

  err_log #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .err_req  (err_req),
    .err_data (err_data),
    .err_ack  (err_ack),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf_cnt  (ovf_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TS_W-1:0]  m_ts;
  logic             m_busy;
  logic             m_pop;
  logic [CNT_W-1:0] m_cnt;
  logic [OVF_W-1:0] m_ovf;
  logic [RD_W-1:0]  m_rd;
  logic [RD_W-1:0]  exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= '0;
    else        m_ts <= m_ts + 32'd1;
  end

  typedef struct {
    logic             req;
    logic [ERR_W-1:0] data;
    logic             rd;
    logic             exp_ack;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_empty;
    logic             exp_rv;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_pop  = 1'b0;
    m_cnt  = '0;
    m_ovf  = '0;
    m_rd   = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model, then compare every output.
  task automatic cyc(input logic req, input logic [ERR_W-1:0] data, input logic rd, input logic clr);
    logic acc, drp, psh;
    err_req  = req;
    err_data = data;
    rd_en    = rd;
    clr_ovf  = clr;
    acc   = !m_busy && req;
    drp   = acc && (m_cnt == CNT_W'(DEPTH));
    psh   = acc && !drp;
    m_pop = rd && (m_cnt != '0);
    if (psh) exp_q.push_back({m_ts, data});
    m_cnt = m_cnt + CNT_W'(psh) - CNT_W'(m_pop);
    if (clr)                            m_ovf = drp ? 16'd1 : 16'd0;
    else if (drp && m_ovf != 16'hFFFF)  m_ovf = m_ovf + 16'd1;
    if (!m_busy && req)      m_busy = 1'b1;
    else if (m_busy && !req) m_busy = 1'b0;
    @(posedge clk);
    #1;
    if (m_pop) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow actual=pop required=entry");
      end else begin
        m_rd = exp_q.pop_front();
      end
    end
    chk("ack",      64'(err_ack),  64'(m_busy));
    chk("count",    64'(count),    64'(m_cnt));
    chk("empty",    64'(empty),    64'(m_cnt == '0));
    chk("full",     64'(full),     64'(m_cnt == CNT_W'(DEPTH)));
    chk("ovf",      64'(ovf_cnt),  64'(m_ovf));
    chk("rd_valid", 64'(rd_valid), 64'(m_pop));
    chk("rd_data",  rd_data,       m_rd);
  endtask

  task automatic handshake(input logic [ERR_W-1:0] data);
    cyc(1'b1, data, 1'b0, 1'b0);
    cyc(1'b0, '0,   1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RD_W-1:0] first_word;

    tbl[0]  = '{1'b1, 32'hDEAD0001, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'hDEAD0001, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'hDEAD0001, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h12345678, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};

    rst_n    = 1'b0;
    err_req  = 1'b0;
    err_data = '0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    model_reset();
    first_word = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",      64'(err_ack),  64'd0);
    chk("rst_rd_data",  rd_data,       64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_full",     64'(full),     64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_ovf",      64'(ovf_cnt),  64'd0);
    #3 rst_n = 1'b1;

    // Single request held three cycles, reads around it.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].data, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_ack", i),   64'(err_ack),  64'(tbl[i].exp_ack));
      chk($sformatf("tbl%0d_count", i), 64'(count),    64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_empty", i), 64'(empty),    64'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_rv", i),    64'(rd_valid), 64'(tbl[i].exp_rv));
      if (i == 4) begin
        first_word = rd_data;
        chk("tbl4_word", 64'(rd_data[ERR_W-1:0]), 64'h0000_0000_DEAD_0001);
      end
      if (i == 6) chk("tbl6_rd_hold", rd_data, first_word);
    end

    // Overfill: DEPTH+3 requests, three dropped.
    for (int i = 0; i < DEPTH + 3; i++) handshake(32'hA000_0000 + 32'(i));
    chk("ovfl_full",  64'(full),    64'd1);
    chk("ovfl_count", 64'(count),   64'(DEPTH));
    chk("ovfl_ovf",   64'(ovf_cnt), 64'd3);

    // Full queue: new request and read in the same cycle.
    cyc(1'b1, 32'hB000_0000, 1'b1, 1'b0);
    chk("fullrw_count", 64'(count),                64'(DEPTH - 1));
    chk("fullrw_ovf",   64'(ovf_cnt),              64'd4);
    chk("fullrw_word",  64'(rd_data[ERR_W-1:0]),   64'h0000_0000_A000_0000);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_last",  64'(rd_data[ERR_W-1:0]), 64'h0000_0000_A000_000F);

    // Reads while empty leave rd_data alone.
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("emptyrd_word",  64'(rd_data[ERR_W-1:0]), 64'h0000_0000_A000_000F);
    chk("emptyrd_count", 64'(count), 64'd0);

    // Saturation: counter preloaded to its maximum, then another drop.
    for (int i = 0; i < DEPTH; i++) handshake(32'hC000_0000 + 32'(i));
    force dut.ovf_q = 16'hFFFF;
    m_ovf = 16'hFFFF;
    cyc(1'b0, '0, 1'b0, 1'b0);
    release dut.ovf_q;
    handshake(32'hD000_0001);
    chk("sat_ovf", 64'(ovf_cnt), 64'h0000_0000_0000_FFFF);
    cyc(1'b1, 32'hD000_0002, 1'b0, 1'b1);
    chk("clrdrop_ovf", 64'(ovf_cnt), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(ovf_cnt), 64'd0);

    // Reset in the middle of a handshake with the request still high.
    cyc(1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ack",   64'(err_ack), 64'd0);
    chk("midrst_count", 64'(count),   64'd0);
    chk("midrst_empty", 64'(empty),   64'd1);
    chk("midrst_ovf",   64'(ovf_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_ack_hold", 64'(err_ack), 64'd0);
    #3 rst_n = 1'b1;
    cyc(1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("relog_word", rd_data, {32'h0000_0000, 32'hBEEF_0002});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
